// File: rtl/dense_layer_sequencer.sv
// Walks one dense_layer_core across a whole layer: fetch row, start core, wait, stream result.
// Build option: define DENSE_SEQ_RELU_EN to clamp negative neuron results to zero at capture.
module dense_layer_sequencer #(
    parameter int NUM_NEURONS = 16,
    parameter int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
    parameter int CNT_W       = $clog2(NUM_NEURONS + 1),
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [CNT_W-1:0]        cmd_num_neurons_i,
    output logic                    wmem_rd_en_o,
    output logic [IDX_W-1:0]        wmem_rd_addr_o,
    output logic                    core_start_o,
    input  logic                    core_done_i,
    input  logic signed [31:0]      core_result_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic signed [31:0]      out_data_o,
    output logic [IDX_W-1:0]        out_index_o,
    output logic                    out_last_o,
    output logic                    busy_o,
    output logic                    layer_done_o,
    output logic                    timeout_err_o
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        COMPUTE,
        OUTPUT
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic signed [31:0] data_q, data_d;
    logic               timeoutErr_q, timeoutErr_d;
    logic               layerDone_q, layerDone_d;

    logic [CNT_W-1:0]   cmdCountSat;
    logic signed [31:0] captureVal;
    logic               isLast;

    // Requests larger than the layer capacity are clamped to the capacity.
    assign cmdCountSat = (cmd_num_neurons_i > CNT_W'(NUM_NEURONS)) ?
                         CNT_W'(NUM_NEURONS) : cmd_num_neurons_i;

    assign isLast = (CNT_W'(idx_q) == (count_q - CNT_W'(1)));

`ifdef DENSE_SEQ_RELU_EN
    assign captureVal = core_result_i[31] ? 32'sd0 : core_result_i;
`else
    assign captureVal = core_result_i;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            idx_q        <= '0;
            tmo_q        <= '0;
            data_q       <= '0;
            timeoutErr_q <= 1'b0;
            layerDone_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            tmo_q        <= tmo_d;
            data_q       <= data_d;
            timeoutErr_q <= timeoutErr_d;
            layerDone_q  <= layerDone_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        idx_d        = idx_q;
        tmo_d        = tmo_q;
        data_d       = data_q;
        timeoutErr_d = timeoutErr_q;
        layerDone_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    count_d      = cmdCountSat;
                    idx_d        = '0;
                    timeoutErr_d = 1'b0;
                    if (cmdCountSat == '0) begin
                        layerDone_d = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                state_d = START;
            end
            START: begin
                tmo_d   = '0;
                state_d = COMPUTE;
            end
            // Done takes priority over an expiring timeout on the same cycle.
            COMPUTE: begin
                if (core_done_i) begin
                    data_d  = captureVal;
                    state_d = OUTPUT;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    timeoutErr_d = 1'b1;
                    layerDone_d  = 1'b1;
                    state_d      = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            OUTPUT: begin
                if (out_ready_i) begin
                    if (isLast) begin
                        layerDone_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready_o    = (state_q == IDLE);
    assign busy_o         = (state_q != IDLE);
    assign wmem_rd_en_o   = (state_q == FETCH);
    assign wmem_rd_addr_o = idx_q;
    assign core_start_o   = (state_q == START);
    assign out_valid_o    = (state_q == OUTPUT);
    assign out_data_o     = data_q;
    assign out_index_o    = idx_q;
    assign out_last_o     = (state_q == OUTPUT) && isLast;
    assign layer_done_o   = layerDone_q;
    assign timeout_err_o  = timeoutErr_q;

endmodule
